// File: rtl/commit_buffer_pkg.sv
// commit_buffer_pkg: shared bus types for the commit buffer (push entry, register write, branch result).
package commit_buffer_pkg;
    localparam int COMMIT_DEPTH = 64;
    typedef logic [$clog2(COMMIT_DEPTH)-1:0] commit_ptr_t;
    typedef enum logic {ENTRY_WB = 1'b0, ENTRY_BR = 1'b1} entry_kind_e;
    typedef struct packed {
        entry_kind_e kind;
        logic [1:0]  notify;
        logic [4:0]  dest_logic;
        logic [15:0] current_pc;
        logic [15:0] new_pc;
    } commit_entry_t;
    typedef struct packed {
        logic        en;
        logic [4:0]  dest_logic;
        logic [31:0] data;
    } commit_info_t;
    typedef struct packed {
        logic        en;
        logic        miss;
        logic        taken;
        logic [31:0] current_pc;
        logic [31:0] jump_addr;
    } branch_result_t;
endpackage

// File: rtl/commit_buffer_if.sv
// commit_buffer_if: dispatch push channel; returns the slot id allocated to the pushed entry.
interface commit_buffer_if;
    import commit_buffer_pkg::*;
    logic          en;
    commit_entry_t commit_entry;
    logic [7:0]    commit_id;
    modport master (output en, commit_entry, input commit_id);
    modport slave (input en, commit_entry, output commit_id);
endinterface

// File: rtl/commit_buffer_perf.sv
// commit_buffer_perf: wrapping retirement and mispredict counters, present only with COMMIT_PERF_EN.
`ifdef COMMIT_PERF_EN
module commit_buffer_perf (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_retire,
    input  logic        i_mispred,
    output logic [31:0] o_retired,
    output logic [31:0] o_mispred
);
    logic [31:0] r_retired, r_mispred;
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retired <= '0;
            r_mispred <= '0;
        end else begin
            r_retired <= r_retired + 32'(i_retire);
            r_mispred <= r_mispred + 32'(i_mispred);
        end
    end
    assign o_retired = r_retired;
    assign o_mispred = r_mispred;
endmodule
`endif

// File: rtl/commit_buffer.sv
// commit_buffer: in-order commit buffer retiring completed entries as register writes and branch results.
// Defining COMMIT_PERF_EN adds o_perf_retired / o_perf_mispred counters.
module commit_buffer
    import commit_buffer_pkg::*;
#(
    parameter int DEPTH = COMMIT_DEPTH
) (
    input  logic           clk,
    input  logic           reset,
    commit_buffer_if.slave push,
    output logic           o_full,
    input  logic           i_wb_en,
    input  logic [7:0]     i_wb_id,
    input  logic [31:0]    i_wb_data,
    input  logic           i_br_en,
    input  logic [7:0]     i_br_id,
    input  logic           i_br_taken,
    input  logic           i_br_raise,
    output logic [1:0]     o_head_notify,
    input  logic           i_notify_ack,
    output commit_info_t   o_commit,
    output branch_result_t o_branch_result
`ifdef COMMIT_PERF_EN
    ,
    output logic [31:0]    o_perf_retired,
    output logic [31:0]    o_perf_mispred
`endif
);
    localparam int AW = $clog2(DEPTH);
    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0] cnt_t;

    ptr_t             r_head, r_tail;
    cnt_t             r_count;
    commit_entry_t    r_entry [DEPTH];
    logic [31:0]      r_data [DEPTH];
    logic [DEPTH-1:0] r_fin, r_raise, r_taken;
    commit_entry_t    w_head;
    ptr_t             w_wb_slot, w_br_slot;
    logic [15:0]      w_pc_inc;
    logic             w_ready, w_is_br, w_retire, w_flush, w_push, w_wb_ok, w_br_ok;

    assign w_wb_slot      = i_wb_id[AW-1:0];
    assign w_br_slot      = i_br_id[AW-1:0];
    assign push.commit_id = 8'(r_tail);
    assign o_full         = r_count == cnt_t'(DEPTH);

    // A completion lands only on an occupied slot: its distance from head must be below count.
    always_comb begin
        w_head        = r_entry[r_head];
        w_is_br       = w_head.kind == ENTRY_BR;
        w_ready       = r_count != '0 && r_fin[r_head];
        o_head_notify = (w_ready && !w_is_br) ? w_head.notify : 2'b00;
        w_retire      = w_ready && (w_is_br || w_head.notify == 2'b00 || i_notify_ack);
        w_flush       = w_retire && w_is_br && r_raise[r_head];
        w_push        = push.en && !o_full && !o_branch_result.miss && !w_flush;
        w_wb_ok       = i_wb_en && (i_wb_id >> AW) == 8'd0 && {1'b0, ptr_t'(w_wb_slot - r_head)} < r_count;
        w_br_ok       = i_br_en && (i_br_id >> AW) == 8'd0 && {1'b0, ptr_t'(w_br_slot - r_head)} < r_count;
        w_pc_inc      = w_head.current_pc + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entry[r_tail] <= push.commit_entry;
            r_raise[r_tail] <= 1'b0;
        end
        if (w_wb_ok) r_data[w_wb_slot] <= i_wb_data;
        if (w_br_ok) begin
            r_taken[w_br_slot] <= i_br_taken;
            r_raise[w_br_slot] <= i_br_raise;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_head          <= '0;
            r_tail          <= '0;
            r_count         <= '0;
            r_fin           <= '0;
            o_commit        <= '0;
            o_branch_result <= '0;
        end else begin
            r_head  <= w_flush ? '0 : r_head + ptr_t'(w_retire);
            r_tail  <= w_flush ? '0 : r_tail + ptr_t'(w_push);
            r_count <= w_flush ? '0 : r_count + cnt_t'(w_push) - cnt_t'(w_retire);
            if (w_push) r_fin[r_tail] <= 1'b0;
            if (w_wb_ok) r_fin[w_wb_slot] <= 1'b1;
            if (w_br_ok) r_fin[w_br_slot] <= 1'b1;
            o_commit <= (w_retire && !w_is_br) ?
                commit_info_t'{en: 1'b1, dest_logic: w_head.dest_logic, data: r_data[r_head]} : '0;
            o_branch_result <= (w_retire && w_is_br) ?
                branch_result_t'{en: 1'b1, miss: r_raise[r_head], taken: r_taken[r_head],
                                 current_pc: 32'(w_head.current_pc),
                                 jump_addr: r_taken[r_head] ? 32'(w_head.new_pc) : 32'(w_pc_inc)} : '0;
        end
    end

`ifdef COMMIT_PERF_EN
    commit_buffer_perf u_perf (
        .clk       (clk),
        .reset     (reset),
        .i_retire  (w_retire),
        .i_mispred (w_flush),
        .o_retired (o_perf_retired),
        .o_mispred (o_perf_mispred)
    );
`endif
endmodule

// File: tb/tb_commit_buffer.sv
// tb_commit_buffer: directed scenarios plus random traffic checked against a queue-based program-order model.
module tb_commit_buffer;
    import commit_buffer_pkg::*;
    localparam int DEPTH = COMMIT_DEPTH;

    logic clk = 1'b0, reset = 1'b1;
    logic full, wb_en = 0, br_en = 0, br_taken = 0, br_raise = 0, ack = 0;
    logic [7:0] wb_id = 0, br_id = 0;
    logic [31:0] wb_data = 0;
    logic [1:0] head_notify;
    commit_info_t commit;
    branch_result_t br_res;
`ifdef COMMIT_PERF_EN
    logic [31:0] perf_retired, perf_mispred;
`endif
    commit_buffer_if push_if ();

    commit_buffer dut (
        .clk(clk), .reset(reset), .push(push_if), .o_full(full),
        .i_wb_en(wb_en), .i_wb_id(wb_id), .i_wb_data(wb_data),
        .i_br_en(br_en), .i_br_id(br_id), .i_br_taken(br_taken), .i_br_raise(br_raise),
        .o_head_notify(head_notify), .i_notify_ack(ack),
        .o_commit(commit), .o_branch_result(br_res)
`ifdef COMMIT_PERF_EN
        , .o_perf_retired(perf_retired), .o_perf_mispred(perf_mispred)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic br; logic [1:0] notify; logic [4:0] dest; logic [15:0] cpc, npc;
        logic fin; logic [31:0] data; logic taken, raise; int id;
    } ment_t;

    ment_t q[$];
    int m_tail = 0;
    logic m_miss = 0;
    commit_info_t exp_commit = '0;
    branch_result_t exp_br = '0;
    int vectors = 0, errors = 0;

    function automatic logic [1:0] m_notify();
        return (q.size() > 0 && q[0].fin && !q[0].br) ? q[0].notify : 2'b00;
    endfunction

    task automatic push_set(input logic br, input logic [1:0] nt, input logic [4:0] dest,
                            input logic [15:0] cpc, input logic [15:0] npc);
        push_if.en = 1'b1;
        push_if.commit_entry = '{kind: entry_kind_e'(br), notify: nt, dest_logic: dest, current_pc: cpc, new_pc: npc};
    endtask

    // One clock: the model decides retirement, admission and completions from the program-order queue.
    task automatic tick();
        logic ret, flush, acc;
        logic [15:0] pc1;
        commit_info_t nc;
        branch_result_t nb;
        ment_t e;
        nc = '0; nb = '0; ret = 0; flush = 0;
        if (!reset && q.size() > 0 && q[0].fin && (q[0].br || q[0].notify == 2'b00 || ack)) begin
            ret = 1;
            if (q[0].br) begin
                pc1 = q[0].cpc + 16'd1;
                nb = '{en: 1'b1, miss: q[0].raise, taken: q[0].taken, current_pc: {16'h0, q[0].cpc},
                       jump_addr: q[0].taken ? {16'h0, q[0].npc} : {16'h0, pc1}};
                flush = q[0].raise;
            end else nc = '{en: 1'b1, dest_logic: q[0].dest, data: q[0].data};
        end
        acc = !reset && push_if.en && q.size() < DEPTH && !m_miss && !flush;
        e = '{br: push_if.commit_entry.kind == ENTRY_BR, notify: push_if.commit_entry.notify,
              dest: push_if.commit_entry.dest_logic, cpc: push_if.commit_entry.current_pc,
              npc: push_if.commit_entry.new_pc, fin: 0, data: 0, taken: 0, raise: 0, id: m_tail};
        foreach (q[i]) begin
            if (wb_en && q[i].id == int'(wb_id)) begin q[i].fin = 1; q[i].data = wb_data; end
            if (br_en && q[i].id == int'(br_id)) begin q[i].fin = 1; q[i].taken = br_taken; q[i].raise = br_raise; end
        end
        @(posedge clk);
        #1;
        if (reset || flush) begin
            q.delete();
            m_tail = 0;
        end else begin
            if (ret) void'(q.pop_front());
            if (acc) begin q.push_back(e); m_tail = (m_tail + 1) % DEPTH; end
        end
        m_miss = nb.miss;
        exp_commit = nc;
        exp_br = nb;
        push_if.en = 0; wb_en = 0; br_en = 0; ack = 0;
    endtask

    task automatic do_reset();
        reset = 1; tick(); reset = 0;
    endtask

    task automatic test_reset();
        reset = 1; tick(); tick();
        vectors++; if (commit !== '0) begin errors++; $display("FAIL reset_commit got %h want 0", commit); end
        vectors++; if (br_res !== '0) begin errors++; $display("FAIL reset_branch got %h want 0", br_res); end
        vectors++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", full); end
        vectors++; if (head_notify !== 2'b00) begin errors++; $display("FAIL reset_notify got %b want 0", head_notify); end
        vectors++; if (push_if.commit_id !== 8'd0) begin errors++; $display("FAIL reset_id got %0d want 0", push_if.commit_id); end
        reset = 0;
    endtask

    task automatic test_in_order();
        int order[3] = '{2, 0, 1};
        logic [31:0] wd[3] = '{32'hA, 32'hB, 32'hC};
        commit_info_t want[3] = '{'{1'b1, 5'd1, 32'hB}, '{1'b1, 5'd2, 32'hC}, '{1'b1, 5'd3, 32'hA}};
        commit_info_t w;
        do_reset();
        for (int i = 0; i < 3; i++) begin push_set(0, 2'b00, 5'(i + 1), 16'h0, 16'h0); tick(); end
        for (int k = 0; k < 6; k++) begin
            if (k < 3) begin wb_en = 1; wb_id = 8'(order[k]); wb_data = wd[k]; end
            tick();
            w = (k >= 2 && k < 5) ? want[k - 2] : '0;
            vectors++; if (commit !== w) begin errors++; $display("FAIL in_order_%0d got %h want %h", k, commit, w); end
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            push_set(0, 2'b00, 5'($urandom_range(0, 31)), 16'h0, 16'h0);
            tick();
            vectors++; if (push_if.commit_id !== 8'(m_tail)) begin errors++; $display("FAIL fill_id got %0d want %0d", push_if.commit_id, m_tail); end
        end
        vectors++; if (full !== 1'b1 || push_if.commit_id !== 8'd0) begin errors++; $display("FAIL full_set got full=%b id=%0d want full=1 id=0", full, push_if.commit_id); end
        push_set(0, 2'b00, 5'd9, 16'h0, 16'h0); tick();
        vectors++; if (full !== 1'b1 || push_if.commit_id !== 8'd0) begin errors++; $display("FAIL push_when_full got full=%b id=%0d want full=1 id=0", full, push_if.commit_id); end
        wb_en = 1; wb_id = 0; wb_data = 32'h55; tick();
        push_set(0, 2'b00, 5'd9, 16'h0, 16'h0); tick();
        vectors++; if (commit !== exp_commit || commit.data !== 32'h55) begin errors++; $display("FAIL full_retire got %h want %h", commit, exp_commit); end
        vectors++; if (full !== 1'b0 || push_if.commit_id !== 8'd0) begin errors++; $display("FAIL full_retire_push got full=%b id=%0d want full=0 id=0", full, push_if.commit_id); end
        push_set(0, 2'b00, 5'd9, 16'h0, 16'h0); tick();
        vectors++; if (full !== 1'b1 || push_if.commit_id !== 8'd1) begin errors++; $display("FAIL slot0_reuse got full=%b id=%0d want full=1 id=1", full, push_if.commit_id); end
    endtask

    task automatic test_mispredict();
        branch_result_t w = '{1'b1, 1'b1, 1'b1, 32'h10, 32'h40};
        do_reset();
        push_set(1, 2'b00, 5'd0, 16'h10, 16'h40); tick();
        push_set(0, 2'b00, 5'd4, 16'h0, 16'h0); tick();
        push_set(0, 2'b00, 5'd5, 16'h0, 16'h0); tick();
        br_en = 1; br_id = 0; br_taken = 1; br_raise = 1; tick();
        push_set(0, 2'b00, 5'd6, 16'h0, 16'h0); tick();
        vectors++; if (br_res !== w) begin errors++; $display("FAIL mispredict_result got %h want %h", br_res, w); end
        vectors++; if (push_if.commit_id !== 8'd0 || full !== 1'b0) begin errors++; $display("FAIL flush_ptr got id=%0d full=%b want 0 0", push_if.commit_id, full); end
        push_set(0, 2'b00, 5'd7, 16'h0, 16'h0); tick();
        vectors++; if (push_if.commit_id !== 8'd0 || br_res !== '0) begin errors++; $display("FAIL miss_cycle_push got id=%0d br=%h want 0 0", push_if.commit_id, br_res); end
        push_set(0, 2'b00, 5'd8, 16'h0, 16'h0); tick();
        vectors++; if (push_if.commit_id !== 8'd1) begin errors++; $display("FAIL post_flush_push got %0d want 1", push_if.commit_id); end
    endtask

    task automatic test_not_taken();
        branch_result_t w = '{1'b1, 1'b0, 1'b0, 32'h20, 32'h21};
        commit_info_t c1 = '{1'b1, 5'd7, 32'h71};
        commit_info_t c2 = '{1'b1, 5'd8, 32'h82};
        do_reset();
        push_set(1, 2'b00, 5'd0, 16'h20, 16'h77); tick();
        push_set(0, 2'b00, 5'd7, 16'h0, 16'h0); tick();
        push_set(0, 2'b00, 5'd8, 16'h0, 16'h0); tick();
        br_en = 1; br_id = 0; br_taken = 0; br_raise = 0; wb_en = 1; wb_id = 1; wb_data = 32'h71; tick();
        wb_en = 1; wb_id = 2; wb_data = 32'h82; tick();
        vectors++; if (br_res !== w || commit.en !== 1'b0) begin errors++; $display("FAIL not_taken got br=%h c=%h want br=%h", br_res, commit, w); end
        tick();
        vectors++; if (commit !== c1 || br_res !== '0) begin errors++; $display("FAIL after_branch_1 got %h want %h", commit, c1); end
        tick();
        vectors++; if (commit !== c2) begin errors++; $display("FAIL after_branch_2 got %h want %h", commit, c2); end
    endtask

    task automatic test_notify();
        commit_info_t w = '{1'b1, 5'd9, 32'h99};
        do_reset();
        push_set(0, 2'b01, 5'd9, 16'h0, 16'h0); ack = 1; tick();
        wb_en = 1; wb_id = 0; wb_data = 32'h99; tick();
        for (int i = 0; i < 5; i++) begin
            vectors++; if (head_notify !== 2'b01) begin errors++; $display("FAIL notify_hold_%0d got %b want 01", i, head_notify); end
            tick();
            vectors++; if (commit !== '0) begin errors++; $display("FAIL notify_no_ack_%0d got %h want 0", i, commit); end
        end
        ack = 1; tick();
        vectors++; if (commit !== w) begin errors++; $display("FAIL notify_ack got %h want %h", commit, w); end
        vectors++; if (head_notify !== 2'b00) begin errors++; $display("FAIL notify_clear got %b want 00", head_notify); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            push_set(0, 2'b00, 5'(i), 16'h0, 16'h0);
            if (i > 0 && i < 3) begin wb_en = 1; wb_id = 8'(i - 1); wb_data = 32'(i); end
            tick();
        end
        reset = 1; wb_en = 1; wb_id = 3; wb_data = 32'h33; push_set(0, 2'b00, 5'd1, 16'h0, 16'h0); tick();
        vectors++; if (commit !== '0 || br_res !== '0) begin errors++; $display("FAIL reset_mid_out got c=%h br=%h want 0 0", commit, br_res); end
        vectors++; if (full !== 1'b0 || push_if.commit_id !== 8'd0 || head_notify !== 2'b00) begin errors++; $display("FAIL reset_mid_state got full=%b id=%0d nt=%b want 0 0 0", full, push_if.commit_id, head_notify); end
        reset = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (commit.en !== 1'b0 || br_res.en !== 1'b0) begin errors++; $display("FAIL reset_mid_quiet_%0d got c=%b br=%b want 0 0", i, commit.en, br_res.en); end
        end
    endtask

    task automatic test_random();
        int k;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            ack = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) != 0)
                push_set($urandom_range(0, 3) == 0, ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
                         5'($urandom), 16'($urandom), 16'($urandom));
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, q.size() - 1);
                if (!q[k].br) begin wb_en = 1; wb_id = 8'(q[k].id); wb_data = $urandom; end
            end
            if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, q.size() - 1);
                if (q[k].br) begin br_en = 1; br_id = 8'(q[k].id); br_taken = 1'($urandom); br_raise = ($urandom_range(0, 7) == 0); end
            end
            if (!wb_en && $urandom_range(0, 15) == 0) begin wb_en = 1; wb_id = 8'($urandom_range(DEPTH, 255)); wb_data = $urandom; end
            tick();
            vectors++; if (commit !== exp_commit) begin errors++; $display("FAIL rnd_commit@%0d got %h want %h", n, commit, exp_commit); end
            vectors++; if (br_res !== exp_br) begin errors++; $display("FAIL rnd_branch@%0d got %h want %h", n, br_res, exp_br); end
            vectors++; if (full !== (q.size() == DEPTH)) begin errors++; $display("FAIL rnd_full@%0d got %b want %b", n, full, q.size() == DEPTH); end
            vectors++; if (push_if.commit_id !== 8'(m_tail)) begin errors++; $display("FAIL rnd_id@%0d got %0d want %0d", n, push_if.commit_id, m_tail); end
            vectors++; if (head_notify !== m_notify()) begin errors++; $display("FAIL rnd_notify@%0d got %b want %b", n, head_notify, m_notify()); end
        end
    endtask

    initial begin
        push_if.en = 0;
        push_if.commit_entry = '0;
        test_reset();
        test_in_order();
        test_full();
        test_mispredict();
        test_not_taken();
        test_notify();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/commit_buffer.md
# commit_buffer

In-order commit (reorder) buffer that sits directly downstream of dispatch. It accepts `CommitEntry` pushes through the `IPushCommit` slave side and hands back each entry's `commit_id`. It absorbs completion results from execution units, then retires entries strictly in program order. Retirement produces `CommitInfo` register writes for the architectural register file and `BranchResult` for the front end; a mispredicted branch flushes the buffer.

## Interface
- `DEPTH`, 64: entry count; power of two, 2..256.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `push`  IPushCommit.slave  —  `en`, `commit_entry` in; `commit_id` out (= tail slot index, zero-extended to 8 bits).
- `full`  out  1  count == DEPTH; pushes ignored while high.
- `wb_cmpl`  in  CompleteInfo-like: `wb_en`, `wb_id`[7:0], `wb_data`[31:0]  writeback completion.
- `br_en`, `br_id`[7:0], `br_taken`, `br_raise`  in  branch completion.
- `head_notify`  out  2  notify bits of head wb entry once fin (uart bit0, sw bit1); 0 otherwise.
- `notify_ack`  in  1  side effect of head done.
- `commit`  out  CommitInfo  registered retirement write.
- `branch_result`  out  BranchResult  registered branch retirement.

## Operation
- State: DEPTH entry array, `head`, `tail` (log2 DEPTH bits, wrap modulo DEPTH), `count` (log2 DEPTH + 1 bits).
- Push: if `en && !full && !branch_result.miss`, store entry at `tail` with `fin` forced 0 and `raise` forced 0; `tail++`, `count++`.
- wb completion: slot `wb_id` gets `fin`=1, `data`=`wb_data`.
- br completion: slot `br_id` gets `fin`=1, `taken`, `raise`.
- Completions to empty slots or ids ≥ DEPTH are ignored. Completion and push to the same slot in one cycle is illegal.
- Retire condition (head valid, `count`>0):
  - wb entry, `fin`, notify==0: retire.
  - wb entry, `fin`, notify≠0: drive `head_notify`; retire only in a cycle with `notify_ack`=1. Hold indefinitely otherwise.
  - branch entry, `fin`: retire.
- At most one retirement per cycle; `head++`, `count--`.
- wb retire registers `commit` = {en=1, dest_logic, data}. dest_logic 0 still asserts `en`; the register file discards it.
- Branch retire registers `branch_result`:
  - en=1, miss=raise, taken, current_pc (zero-extended to 32).
  - jump_addr = taken ? new_pc : current_pc+1 (16-bit add, zero-extended).
- Flush: a retiring branch with raise=1 sets head=tail=0 and count=0 at the same edge. Pushes in that cycle and in the following cycle (while `branch_result.miss`=1) are dropped.
- Push and retire in one cycle: count unchanged. When full, the push is rejected even if a retire happens that cycle.

## Timing
- Reset: head=tail=count=0; all entries' fin=0; `commit.en`=0; `branch_result` all fields 0; `full`=0; `head_notify`=0; `commit_id`=0.
- `commit_id` is combinational from `tail`.
- Completion written at edge t is retire-eligible in cycle t+1; there is no bypass.
- Retirement decision in cycle t appears on `commit`/`branch_result` for exactly one cycle, t+1.
- Back-to-back completed entries retire one per cycle.
- `notify_ack` is sampled only when `head_notify`≠0; otherwise it is ignored.
- `reset` mid-operation discards all entries. No outputs pulse on the reset cycle.

## Configuration
- `COMMIT_PERF_EN`: when defined, adds outputs `perf_retired`[31:0] and `perf_mispred`[31:0]:
  - free-running wrapping counters of retirements and raise=1 branch retirements;
  - reset to 0; increment at the retirement edge.
- Without the macro, these ports and registers do not exist; behaviour is otherwise identical.

## Structure
- `CommitEntry`, `CommitInfo`, `BranchResult`, `IPushCommit` stay in the shared bus header.
- Add to the shared package: `COMMIT_DEPTH` default constant and `commit_ptr_t` typedef.
- One sub-module is natural: `commit_perf`, the two counters, instantiated only under `COMMIT_PERF_EN`.

## Test plan
- Push 3 wb entries (dest 1,2,3), complete ids 2,0,1 with data 0xA,0xB,0xC -> commits in order dest1=0xB, dest2=0xC, dest3=0xA on consecutive cycles.
- Push 64 entries -> `full`=1, 65th push ignored, `commit_id` wraps to 0; retire one, push one -> slot 0 reused, id 0.
- Branch current_pc=0x10, new_pc=0x40, complete taken=1 raise=1 with 2 younger entries -> branch_result {en,miss=1,taken=1,current_pc=0x10,jump_addr=0x40}, count=0, push in miss cycle dropped.
- Not-taken branch pc=0x20 raise=0 -> jump_addr=0x21, miss=0, following entries retire normally.
- wb entry notify=01 fin -> `head_notify`=01 held 5 cycles without ack; ack -> commit next cycle.
- Assert `reset` with 10 entries pending -> all outputs 0, full=0, `commit_id`=0, no commits.
